pixel_tick_sequencer: RTL and testbench

Downstream consumer of the clock divider's `out` strobe. It turns each divided-clock rising edge into one pixel-slot event and walks a raster of IMG_W x IMG_H pixels, producing pixel coordinates and a linear address for the masking datapath. Everything runs in the single system clock domain. The divider output is sampled as a level, not used as a clock.

---
 rtl/pixel_tick_sequencer_if.sv | 27 ++
 rtl/pixel_tick_sequencer.sv | 148 ++++++++++++++
 tb/tb_pixel_tick_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_tick_sequencer_if.sv
// rtl/pixel_tick_sequencer_if.sv - handshake and pixel bus between the tick source/controller and the sequencer
interface pixel_tick_sequencer_if #(
  parameter int XY_W   = 8,
  parameter int ADDR_W = 16
);
  logic              tick_in;
  logic              start;
  logic              abort;
  logic              busy;
  logic              pix_valid;
  logic [XY_W-1:0]   pix_x;
  logic [XY_W-1:0]   pix_y;
  logic [ADDR_W-1:0] pix_addr;
  logic              line_end;
  logic              frame_end;
  logic              done;

  modport master (
    output tick_in, start, abort,
    input  busy, pix_valid, pix_x, pix_y, pix_addr, line_end, frame_end, done
  );

  modport slave (
    input  tick_in, start, abort,
    output busy, pix_valid, pix_x, pix_y, pix_addr, line_end, frame_end, done
  );
endinterface

// File: rtl/pixel_tick_sequencer.sv
// rtl/pixel_tick_sequencer.sv - turns divided-clock rising edges into raster pixel slots
module pixel_tick_sequencer #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16,
  parameter int XY_W   = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  pixel_tick_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              tick_q;
  logic              tick_edge;
  logic [XY_W-1:0]   x_q, x_d;
  logic [XY_W-1:0]   y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              emit;
  logic              last_col;
  logic              last_row;

  logic              pix_valid_q, pix_valid_d;
  logic [XY_W-1:0]   pix_x_q, pix_x_d;
  logic [XY_W-1:0]   pix_y_q, pix_y_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic              line_end_q, line_end_d;
  logic              frame_end_q, frame_end_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // The divider output is a level; only its low-to-high transition counts.
  assign tick_edge = bus.tick_in & ~tick_q;
  assign last_col  = (x_q == XY_W'(IMG_W - 1));
  assign last_row  = (y_q == XY_W'(IMG_H - 1));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    emit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        x_d    = '0;
        y_d    = '0;
        addr_d = '0;
        if (bus.start && !bus.abort) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end else if (tick_edge) begin
          emit = 1'b1;
          if (last_col && last_row) begin
            state_d = S_DONE;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
          end else if (last_col) begin
            x_d    = '0;
            y_d    = y_q + XY_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            x_d    = x_q + XY_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        x_d     = '0;
        y_d     = '0;
        addr_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        x_d     = '0;
        y_d     = '0;
        addr_d  = '0;
      end
    endcase
  end

  // Coordinates hold between pulses; the qualifiers only ever ride on pix_valid.
  always_comb begin
    pix_valid_d = emit;
    line_end_d  = emit & last_col;
    frame_end_d = emit & last_col & last_row;
    pix_x_d     = emit ? x_q : pix_x_q;
    pix_y_d     = emit ? y_q : pix_y_q;
    pix_addr_d  = emit ? addr_q : pix_addr_q;
    done_d      = (state_q == S_DONE);
    // busy stays up through the done pulse, which trails the DONE state by one cycle.
    busy_d      = (state_d != S_IDLE) || (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tick_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_addr_q  <= '0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= bus.tick_in;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_addr_q  <= pix_addr_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_x     = pix_x_q;
  assign bus.pix_y     = pix_y_q;
  assign bus.pix_addr  = pix_addr_q;
  assign bus.line_end  = line_end_q;
  assign bus.frame_end = frame_end_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_pixel_tick_sequencer.sv
// tb/tb_pixel_tick_sequencer.sv - directed self-checking bench for pixel_tick_sequencer on a 4x2 raster
module tb_pixel_tick_sequencer;
  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct {
    int         cyc;
    logic [2:0] addr;
    logic [1:0] x;
    logic [1:0] y;
    logic       le;
    logic       fe;
  } pix_t;

  pix_t pix_log[$];
  int   done_log[$];
  bit   busy_hist [0:4095];

  pixel_tick_sequencer_if #(.XY_W(2), .ADDR_W(3)) bus ();

  pixel_tick_sequencer #(
    .IMG_W (4),
    .IMG_H (2),
    .ADDR_W(3),
    .XY_W  (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      pix_t p;
      if (cyc < 4096) busy_hist[cyc] = bus.busy;
      if (bus.pix_valid === 1'b1) begin
        p.cyc  = cyc;
        p.addr = bus.pix_addr;
        p.x    = bus.pix_x;
        p.y    = bus.pix_y;
        p.le   = bus.line_end;
        p.fe   = bus.frame_end;
        pix_log.push_back(p);
      end
      if (bus.done === 1'b1) done_log.push_back(cyc);
    end
  end

  task automatic drive(input bit t, input bit s, input bit a);
    @(negedge clk);
    bus.tick_in = t;
    bus.start   = s;
    bus.abort   = a;
  endtask

  task automatic clear_logs();
    pix_log.delete();
    done_log.delete();
  endtask

  task automatic test_reset();
    bus.tick_in = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.pix_valid, bus.line_end, bus.frame_end, bus.done} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_flags got %b exp 00000",
               {bus.busy, bus.pix_valid, bus.line_end, bus.frame_end, bus.done});
    end
    n_checks++;
    if ({bus.pix_x, bus.pix_y, bus.pix_addr} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_coords got x=%0d y=%0d addr=%0d exp 0 0 0", bus.pix_x, bus.pix_y, bus.pix_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.pix_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release got busy=%b pix_valid=%b exp 0 0", bus.busy, bus.pix_valid);
    end
  endtask

  task automatic test_small_frame();
    int b;
    clear_logs();
    drive(0, 1, 0);
    b = cyc;
    for (int i = 0; i < 20; i++) drive(i % 2 == 0, 0, 0);
    drive(0, 0, 0);
    n_checks++;
    if (busy_hist[b+1] !== 1'b1) begin
      n_errors++;
      $display("FAIL small_busy_rise got %b exp 1", busy_hist[b+1]);
    end
    n_checks++;
    if (pix_log.size() != 8) begin
      n_errors++;
      $display("FAIL small_count got %0d exp 8", pix_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic [8:0] got, exp;
        got = {pix_log[i].addr, pix_log[i].x, pix_log[i].y, pix_log[i].le, pix_log[i].fe};
        exp = {3'(i), 2'(i % 4), 2'(i / 4), (i % 4) == 3, i == 7};
        n_checks++;
        if (got !== exp || pix_log[i].cyc != b + 2 + 2 * i) begin
          n_errors++;
          $display("FAIL small_pix%0d got {a,x,y,le,fe}=%b cyc=%0d exp %b cyc=%0d",
                   i, got, pix_log[i].cyc - b, exp, 2 + 2 * i);
        end
      end
    end
    n_checks++;
    if (done_log.size() != 1 || done_log[0] != b + 17) begin
      n_errors++;
      $display("FAIL small_done got n=%0d cyc=%0d exp n=1 cyc=17", done_log.size(),
               done_log.size() > 0 ? done_log[0] - b : -1);
    end
    n_checks++;
    if (busy_hist[b+17] !== 1'b1 || busy_hist[b+18] !== 1'b0) begin
      n_errors++;
      $display("FAIL small_busy_fall got %b%b exp 10", busy_hist[b+17], busy_hist[b+18]);
    end
    n_checks++;
    if (bus.pix_addr !== 3'd7 || bus.pix_x !== 2'd3 || bus.pix_y !== 2'd1 || bus.line_end !== 1'b0) begin
      n_errors++;
      $display("FAIL small_hold got addr=%0d x=%0d y=%0d le=%b exp 7 3 1 0",
               bus.pix_addr, bus.pix_x, bus.pix_y, bus.line_end);
    end
  endtask

  task automatic test_slow_tick();
    int b;
    clear_logs();
    drive(0, 1, 0);
    b = cyc;
    for (int i = 0; i < 40; i++) drive(i % 4 != 3, 0, 0);
    drive(0, 0, 0);
    n_checks++;
    if (pix_log.size() != 8) begin
      n_errors++;
      $display("FAIL slow_count got %0d exp 8", pix_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (pix_log[i].addr !== 3'(i) || pix_log[i].cyc != b + 2 + 4 * i) begin
          n_errors++;
          $display("FAIL slow_pix%0d got addr=%0d cyc=%0d exp addr=%0d cyc=%0d",
                   i, pix_log[i].addr, pix_log[i].cyc - b, i, 2 + 4 * i);
        end
      end
    end
    n_checks++;
    if (done_log.size() != 1 || done_log[0] != b + 31) begin
      n_errors++;
      $display("FAIL slow_done got n=%0d exp n=1 cyc=31", done_log.size());
    end
  endtask

  task automatic test_start_edge();
    int b;
    clear_logs();
    drive(1, 1, 0);
    b = cyc;
    drive(0, 0, 0);
    for (int i = 0; i < 20; i++) drive(i % 2 == 0, 0, 0);
    drive(0, 0, 0);
    n_checks++;
    if (pix_log.size() != 8) begin
      n_errors++;
      $display("FAIL sedge_count got %0d exp 8", pix_log.size());
    end else begin
      n_checks++;
      if (pix_log[0].addr !== 3'd0 || pix_log[0].cyc != b + 3) begin
        n_errors++;
        $display("FAIL sedge_first got addr=%0d cyc=%0d exp addr=0 cyc=3",
                 pix_log[0].addr, pix_log[0].cyc - b);
      end
      n_checks++;
      if (pix_log[7].addr !== 3'd7 || pix_log[7].fe !== 1'b1) begin
        n_errors++;
        $display("FAIL sedge_last got addr=%0d fe=%b exp 7 1", pix_log[7].addr, pix_log[7].fe);
      end
    end
    n_checks++;
    if (done_log.size() != 1 || done_log[0] != b + 18) begin
      n_errors++;
      $display("FAIL sedge_done got n=%0d exp n=1 cyc=18", done_log.size());
    end
  endtask

  task automatic test_abort();
    int b;
    clear_logs();
    drive(0, 1, 1);
    b = cyc;
    drive(0, 0, 0);
    n_checks++;
    if (busy_hist[b+1] !== 1'b0) begin
      n_errors++;
      $display("FAIL start_abort_idle got busy=%b exp 0", busy_hist[b+1]);
    end
    drive(0, 1, 0);
    b = cyc;
    for (int i = 0; i < 12; i++) drive(i % 2 == 0, 0, 0);
    drive(1, 0, 1);
    for (int i = 0; i < 10; i++) drive(i % 2 == 1, 0, 0);
    drive(0, 0, 0);
    n_checks++;
    if (pix_log.size() != 6 || pix_log[pix_log.size()-1].addr !== 3'd5) begin
      n_errors++;
      $display("FAIL abort_pixels got n=%0d exp n=6 last addr=5", pix_log.size());
    end
    n_checks++;
    if (busy_hist[b+13] !== 1'b1 || busy_hist[b+14] !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_busy got %b%b exp 10", busy_hist[b+13], busy_hist[b+14]);
    end
    n_checks++;
    if (done_log.size() != 0) begin
      n_errors++;
      $display("FAIL abort_no_done got %0d exp 0", done_log.size());
    end
    clear_logs();
    drive(0, 1, 0);
    b = cyc;
    for (int i = 0; i < 20; i++) drive(i % 2 == 0, 0, 0);
    drive(0, 0, 0);
    n_checks++;
    if (pix_log.size() != 8 || pix_log[0].addr !== 3'd0 || pix_log[0].cyc != b + 2 || pix_log[7].addr !== 3'd7) begin
      n_errors++;
      $display("FAIL abort_restart got n=%0d exp n=8 addr 0..7", pix_log.size());
    end
  endtask

  task automatic test_async_reset();
    int b;
    clear_logs();
    drive(0, 1, 0);
    b = cyc;
    for (int i = 0; i < 6; i++) drive(i % 2 == 0, 0, 0);
    #2;
    n_checks++;
    if (bus.pix_addr !== 3'd2 || bus.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL areset_pre got addr=%0d busy=%b exp 2 1", bus.pix_addr, bus.busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.pix_valid, bus.done, bus.pix_x, bus.pix_y, bus.pix_addr} !== 10'b0) begin
      n_errors++;
      $display("FAIL areset_clear got busy=%b addr=%0d x=%0d y=%0d exp all 0",
               bus.busy, bus.pix_addr, bus.pix_x, bus.pix_y);
    end
    drive(0, 0, 0);
    rst_n = 1'b1;
    drive(0, 0, 0);
    clear_logs();
    drive(0, 1, 0);
    b = cyc;
    for (int i = 0; i < 20; i++) drive(i % 2 == 0, i == 3 || i == 15, 0);
    drive(0, 0, 0);
    n_checks++;
    if (pix_log.size() != 8) begin
      n_errors++;
      $display("FAIL areset_count got %0d exp 8", pix_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (pix_log[i].addr !== 3'(i) || pix_log[i].cyc != b + 2 + 2 * i) begin
          n_errors++;
          $display("FAIL areset_pix%0d got addr=%0d cyc=%0d exp addr=%0d cyc=%0d",
                   i, pix_log[i].addr, pix_log[i].cyc - b, i, 2 + 2 * i);
        end
      end
    end
    n_checks++;
    if (done_log.size() != 1 || busy_hist[b+18] !== 1'b0) begin
      n_errors++;
      $display("FAIL areset_start_ignored got done=%0d busy=%b exp 1 0", done_log.size(), busy_hist[b+18]);
    end
  endtask

  initial begin
    test_reset();
    test_small_frame();
    test_slow_tick();
    test_start_edge();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
